// File: rtl/ntt_coef_reader.sv
// ntt_coef_reader: sequences BRAM reads over a linear or bit-reversed range and streams the data out
module ntt_coef_reader #(
  parameter int DW = 24,
  parameter int AW = 7,
  parameter int RD_LAT = 1,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic          bitrev,
  output logic          busy,
  output logic          done,
  output logic          enb,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] doutb,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 2);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [AW-1:0] base_q, idx_r, addr_n;
  logic [AW:0] len_q, idx;
  logic rev_q, enb_last, push, pop, credit, last_issue;
  logic [RD_LAT-1:0] dl_v, dl_l;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_l;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count, outstanding;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    idx_r = '0;
    for (int i = 0; i < AW; i++) idx_r[i] = idx[AW-1-i];
  end
  // credits count every read not yet popped, including the one presented this cycle
  always_comb begin
    outstanding = count + CW'(enb) - CW'(pop);
    for (int i = 0; i < RD_LAT; i++) outstanding = outstanding + CW'(dl_v[i]);
  end
  assign credit = outstanding < CW'(FIFO_DEPTH);
  assign addr_n = base_q + (rev_q ? idx_r : idx[AW-1:0]);
  assign last_issue = idx == len_q - 1'b1;
  assign busy = state != IDLE;
  assign push = dl_v[RD_LAT-1];
  assign m_valid = count != '0;
  assign pop = m_valid & m_ready;
  assign m_data = m_valid ? mem[rp] : '0;
  assign m_last = m_valid & mem_l[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      enb <= 1'b0;
      enb_last <= 1'b0;
      addrb <= '0;
      done <= 1'b0;
      idx <= '0;
      base_q <= '0;
      len_q <= '0;
      rev_q <= 1'b0;
    end else begin
      done <= 1'b0;
      enb <= 1'b0;
      enb_last <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (len == '0) done <= 1'b1;
          else begin
            base_q <= base;
            len_q <= len;
            rev_q <= bitrev;
            idx <= {{AW{1'b0}}, 1'b1};
            enb <= 1'b1;
            addrb <= base;
            enb_last <= len == {{AW{1'b0}}, 1'b1};
            state <= len == {{AW{1'b0}}, 1'b1} ? DRAIN : RUN;
          end
        end
        RUN: if (credit) begin
          enb <= 1'b1;
          addrb <= addr_n;
          idx <= idx + 1'b1;
          enb_last <= last_issue;
          if (last_issue) state <= DRAIN;
        end
        DRAIN: if (pop && m_last) begin
          state <= IDLE;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_v <= '0;
      dl_l <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      dl_v[0] <= enb;
      dl_l[0] <= enb_last;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_l[i] <= dl_l[i-1];
      end
      if (push) begin
        mem[wp] <= doutb;
        mem_l[wp] <= dl_l[RD_LAT-1];
        wp <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_ntt_coef_reader.sv
// tb_ntt_coef_reader: scoreboard bench for the coefficient read sequencer
module tb_ntt_coef_reader;
  localparam int DW = 24, AW = 7, RD_LAT = 1, FD = RD_LAT + 2;
  logic clk = 0, rst = 1, start = 0, bitrev = 0, m_ready = 1;
  logic busy, done, enb, m_valid, m_last;
  logic [AW-1:0] base = '0, addrb;
  logic [AW:0] len = '0;
  logic [DW-1:0] doutb, m_data;
  logic [DW-1:0] bram [2**AW];
  logic [AW-1:0] addr_q[$];
  logic [DW:0] exp_q[$];
  logic [AW-1:0] ea;
  logic [DW:0] ed, hold_v;
  logic hold = 0, b1, bd;
  int checks = 0, errors = 0, enb_cnt = 0, xfer_cnt = 0;
  int fv, lc, dc, late;

  ntt_coef_reader #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len), .bitrev(bitrev),
    .busy(busy), .done(done), .enb(enb), .addrb(addrb), .doutb(doutb),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (enb) doutb <= bram[addrb];

  function automatic logic [AW-1:0] rev(input logic [AW-1:0] x);
    for (int i = 0; i < AW; i++) rev[i] = x[AW-1-i];
  endfunction

  task automatic expect_cmd(input logic [AW-1:0] b, input int l, input logic br);
    for (int i = 0; i < l; i++) begin
      logic [AW-1:0] a;
      a = b + (br ? rev(i[AW-1:0]) : i[AW-1:0]);
      addr_q.push_back(a);
      exp_q.push_back({i == l - 1, DW'(a) * DW'(3)});
    end
  endtask

  always @(negedge clk) begin
    if (rst) hold = 0;
    else begin
      if (enb) begin
        enb_cnt++;
        checks++;
        if (addr_q.size() == 0) begin errors++; $display("FAIL extra_enb addrb=%0d expected no read", addrb); end
        else begin
          ea = addr_q.pop_front();
          if (addrb !== ea) begin errors++; $display("FAIL addrb got %0d want %0d", addrb, ea); end
        end
      end
      if (hold) begin
        checks++;
        if (!m_valid || {m_last, m_data} !== hold_v) begin
          errors++; $display("FAIL stall_stable got v=%0b %h want v=1 %h", m_valid, {m_last, m_data}, hold_v);
        end
      end
      if (m_valid && m_ready) begin
        xfer_cnt++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL extra_xfer data=%0d expected none", m_data); end
        else begin
          ed = exp_q.pop_front();
          if ({m_last, m_data} !== ed) begin
            errors++; $display("FAIL data got last=%0b %0d want last=%0b %0d", m_last, m_data, ed[DW], ed[DW-1:0]);
          end
        end
      end
      checks++;
      if (enb_cnt - xfer_cnt > FD) begin errors++; $display("FAIL occupancy got %0d want <= %0d", enb_cnt - xfer_cnt, FD); end
      hold = m_valid && !m_ready;
      hold_v = {m_last, m_data};
    end
  end

  task automatic go(input logic [AW-1:0] b, input int l, input logic br, input int rmode, input int spur, input int maxc);
    @(posedge clk); #1;
    enb_cnt = 0; xfer_cnt = 0; fv = -1; lc = -1; dc = -1; late = 0; b1 = 0; bd = 1;
    expect_cmd(b, l, br);
    start = 1; base = b; len = l[AW:0]; bitrev = br;
    m_ready = rmode == 0 || $urandom_range(0, 9) < 3;
    for (int c = 1; c <= maxc && dc < 0; c++) begin
      @(posedge clk); #1;
      start = c == spur;
      if (c == spur) begin base = 7'd77; len = 8'd5; bitrev = 0; end
      m_ready = rmode == 0 || (!(c >= 30 && c < 50) && $urandom_range(0, 9) < 3);
      @(negedge clk);
      if (c == 1) b1 = busy;
      if (m_valid && fv < 0) fv = c;
      if (m_valid && m_ready && m_last) lc = c;
      if (rmode != 0 && enb && c >= 30 + RD_LAT + 2 && c < 50) late++;
      if (done) begin dc = c; bd = busy; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, enb, addrb, m_valid, m_last, m_data} !== '0) begin
      errors++; $display("FAIL reset_values got %b want all zero", {busy, done, enb, addrb, m_valid, m_last, m_data});
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_linear;
    go(0, 128, 0, 0, 0, 400);
    checks++; if (fv !== 3) begin errors++; $display("FAIL lin_first_valid got %0d want 3", fv); end
    checks++; if (lc !== 130) begin errors++; $display("FAIL lin_last got %0d want 130", lc); end
    checks++; if (dc !== 131) begin errors++; $display("FAIL lin_done got %0d want 131", dc); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL lin_busy_c1 got %0b want 1", b1); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL lin_busy_done got %0b want 0", bd); end
    checks++; if (xfer_cnt !== 128) begin errors++; $display("FAIL lin_count got %0d want 128", xfer_cnt); end
  endtask

  task automatic test_wrap;
    go(120, 16, 0, 0, 0, 100);
    checks++; if (xfer_cnt !== 16) begin errors++; $display("FAIL wrap_count got %0d want 16", xfer_cnt); end
    checks++; if (lc !== 18) begin errors++; $display("FAIL wrap_last got %0d want 18", lc); end
    checks++; if (dc !== 19) begin errors++; $display("FAIL wrap_done got %0d want 19", dc); end
  endtask

  task automatic test_bitrev;
    go(0, 128, 1, 0, 0, 400);
    checks++; if (dc !== 131) begin errors++; $display("FAIL rev_done got %0d want 131", dc); end
    checks++; if (xfer_cnt !== 128) begin errors++; $display("FAIL rev_count got %0d want 128", xfer_cnt); end
    checks++; if (addr_q.size() !== 0) begin errors++; $display("FAIL rev_addr_left got %0d want 0", addr_q.size()); end
  endtask

  task automatic test_backpressure;
    go(5, 128, 0, 1, 0, 3000);
    m_ready = 1;
    checks++; if (dc < 0) begin errors++; $display("FAIL bp_done got timeout want done"); end
    checks++; if (xfer_cnt !== 128) begin errors++; $display("FAIL bp_count got %0d want 128", xfer_cnt); end
    checks++; if (late !== 0) begin errors++; $display("FAIL bp_enb_stall got %0d late reads want 0", late); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_edges;
    go(5, 0, 0, 0, 0, 10);
    checks++; if (dc !== 1) begin errors++; $display("FAIL len0_done got %0d want 1", dc); end
    checks++; if (enb_cnt !== 0) begin errors++; $display("FAIL len0_enb got %0d want 0", enb_cnt); end
    go(9, 1, 0, 0, 0, 20);
    checks++; if (xfer_cnt !== 1) begin errors++; $display("FAIL len1_count got %0d want 1", xfer_cnt); end
    checks++; if (lc !== 3) begin errors++; $display("FAIL len1_last got %0d want 3", lc); end
    checks++; if (dc !== 4) begin errors++; $display("FAIL len1_done got %0d want 4", dc); end
    go(10, 20, 1, 0, 5, 100);
    checks++; if (xfer_cnt !== 20) begin errors++; $display("FAIL spur_count got %0d want 20", xfer_cnt); end
    checks++; if (dc !== 23) begin errors++; $display("FAIL spur_done got %0d want 23", dc); end
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1;
    logic bz = 0;
    @(posedge clk); #1;
    enb_cnt = 0; xfer_cnt = 0;
    expect_cmd(0, 4, 0);
    expect_cmd(50, 6, 0);
    start = 1; base = 0; len = 8'd4; bitrev = 0; m_ready = 1;
    for (int c = 1; c <= 30 && d2 < 0; c++) begin
      @(posedge clk); #1;
      start = c == 7;
      if (c == 7) begin base = 7'd50; len = 8'd6; end
      @(negedge clk);
      if (done && d1 < 0) d1 = c;
      else if (done) d2 = c;
      if (c == 8) bz = busy;
    end
    checks++; if (d1 !== 7) begin errors++; $display("FAIL b2b_done1 got %0d want 7", d1); end
    checks++; if (d2 !== 16) begin errors++; $display("FAIL b2b_done2 got %0d want 16", d2); end
    checks++; if (bz !== 1'b1) begin errors++; $display("FAIL b2b_busy got %0b want 1", bz); end
    checks++; if (xfer_cnt !== 10) begin errors++; $display("FAIL b2b_count got %0d want 10", xfer_cnt); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    enb_cnt = 0; xfer_cnt = 0;
    expect_cmd(0, 128, 0);
    start = 1; base = 0; len = 8'd128; bitrev = 0; m_ready = 1;
    for (int c = 1; c <= 40; c++) begin @(posedge clk); #1 start = 0; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    addr_q.delete();
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({busy, done, enb, addrb, m_valid, m_last, m_data} !== '0) begin
      errors++; $display("FAIL midrst_values got %b want all zero", {busy, done, enb, addrb, m_valid, m_last, m_data});
    end
    go(0, 128, 0, 0, 0, 400);
    checks++; if (fv !== 3) begin errors++; $display("FAIL midrst_first got %0d want 3", fv); end
    checks++; if (dc !== 131) begin errors++; $display("FAIL midrst_done got %0d want 131", dc); end
    checks++; if (xfer_cnt !== 128) begin errors++; $display("FAIL midrst_count got %0d want 128", xfer_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) bram[i] = DW'(i * 3);
    test_reset;
    test_linear;
    test_wrap;
    test_bitrev;
    test_backpressure;
    test_edges;
    test_back_to_back;
    test_reset_mid;
    checks++;
    if (exp_q.size() !== 0 || addr_q.size() !== 0) begin
      errors++; $display("FAIL leftover got %0d/%0d want 0/0", exp_q.size(), addr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
